output_packer: RTL and testbench

Packs the stream of quantized output activations produced by the PE array (downstream of the router/SRAM front end) into SRAM_DATA_WIDTH-bit words and writes them sequentially into the output SRAM. Element width follows the same precision mode as the router: 8, 4 or 2 bits. Elements are packed LSB-first. One output map of i_o_size × i_o_size elements is written per i_start. A trailing partial word is flushed with zero-filled upper lanes.

---
 rtl/output_packer.sv | 151 +++++++++++++++
 tb/tb_output_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_packer.sv
// Packs narrow PE output elements LSB-first into SRAM-wide words and writes
// them to sequential output SRAM addresses, one output map per i_start.
module output_packer #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic [1:0]                 i_p_mode,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_o_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_o_size,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_write_en,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int SHAMT_W = $clog2(SRAM_DATA_WIDTH);
  localparam int LANE_W  = SHAMT_W - 1;
  localparam int CNT_W   = 2 * ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 wsh_q, wsh_d;        // log2 of element width
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]           total_q, total_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [SRAM_DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [7:0]                 elem;
  logic [SHAMT_W-1:0]         shamt;
  logic [SRAM_DATA_WIDTH-1:0] lane_bits;
  logic [LANE_W-1:0]          lane_max;
  logic [CNT_W-1:0]           size_ext;
  logic                       last_elem;
  logic                       word_done;

  always_comb begin
    elem = i_data;
    unique case (wsh_q)
      2'd2:    elem = {4'b0, i_data[3:0]};
      2'd1:    elem = {6'b0, i_data[1:0]};
      default: elem = i_data;
    endcase
    shamt     = SHAMT_W'(lane_q) << wsh_q;
    lane_bits = SRAM_DATA_WIDTH'(elem) << shamt;
    lane_max  = LANE_W'((SRAM_DATA_WIDTH >> wsh_q) - 1);
    size_ext  = CNT_W'(i_o_size);
    last_elem = (count_q + 1'b1) == total_q;
    word_done = (lane_q == lane_max) || last_elem;
  end

  always_comb begin
    state_d   = state_q;
    wsh_d     = wsh_q;
    addr_d    = addr_q;
    total_d   = total_q;
    count_d   = count_q;
    lane_d    = lane_q;
    shadow_d  = shadow_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          unique case (i_p_mode)
            2'b01:   wsh_d = 2'd2;
            2'b10:   wsh_d = 2'd1;
            default: wsh_d = 2'd3;
          endcase
          addr_d   = i_o_start_addr;
          total_d  = size_ext * size_ext;
          count_d  = '0;
          lane_d   = '0;
          shadow_d = '0;
          state_d  = (i_o_size == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (i_valid) begin
          count_d = count_q + 1'b1;
          if (word_done) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shadow_q | lane_bits;
            addr_d    = addr_q + 1'b1;
            shadow_d  = '0;
            lane_d    = '0;
          end else begin
            shadow_d = shadow_q | lane_bits;
            lane_d   = lane_q + 1'b1;
          end
          if (last_elem) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort and reset share one path: any pending write is dropped with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) begin
      state_q   <= IDLE;
      wsh_q     <= 2'd3;
      addr_q    <= '0;
      total_q   <= '0;
      count_q   <= '0;
      lane_q    <= '0;
      shadow_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wsh_q     <= wsh_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      count_q   <= count_d;
      lane_q    <= lane_d;
      shadow_q  <= shadow_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_ready      = (state_q == ACTIVE);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_write_en   = wr_en_q;
  assign o_write_addr = wr_addr_q;
  assign o_data_out   = wr_data_q;

endmodule

// File: tb/tb_output_packer.sv
// Bench for output_packer: table of jobs with a packing model feeding an
// expected-write queue, plus abort and start/clear collision sequences.
module tb_output_packer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_reg_clear = 1'b0;
  logic [1:0]  i_p_mode = 2'b00;
  logic        i_start = 1'b0;
  logic [7:0]  i_o_start_addr = '0;
  logic [7:0]  i_o_size = '0;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_write_en;
  logic [7:0]  o_write_addr;
  logic [63:0] o_data_out;
  logic        o_busy;
  logic        o_done;

  output_packer #(.SRAM_DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_reg_clear(i_reg_clear), .i_p_mode(i_p_mode),
    .i_start(i_start), .i_o_start_addr(i_o_start_addr), .i_o_size(i_o_size),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_write_en(o_write_en),
    .o_write_addr(o_write_addr), .o_data_out(o_data_out), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  addr;
    logic [7:0]  size;
    int          kind;   // 0: i+1, 1: 0xFF, 2: i
    bit          gap;
    int          nw;
    logic [63:0] w0;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  vec_t        vt[7];
  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          job_wr = 0;
  int          done_cnt = 0;
  logic [63:0] first_word = '0;

  logic [63:0] m_word;
  int unsigned m_w;
  int unsigned m_lanes;
  logic [7:0]  m_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Elements enter at the top of the word and shift down; a partial word is
  // shifted the rest of the way so its unused upper lanes are zero.
  task automatic mdl_push(input logic [7:0] e, input bit last);
    logic [63:0] ev;
    ev = 64'(e) & ((64'd1 << m_w) - 64'd1);
    m_word = (m_word >> m_w) | (ev << (64 - m_w));
    m_lanes++;
    if (m_lanes == 64 / m_w || last) begin
      exp_q.push_back('{addr: m_addr, data: m_word >> ((64 / m_w - m_lanes) * m_w)});
      m_addr++;
      m_word = '0;
      m_lanes = 0;
    end
  endtask

  function automatic logic [7:0] elem_of(input int kind, input int i);
    if (kind == 0) return 8'(i + 1);
    if (kind == 1) return 8'hFF;
    return 8'(i);
  endfunction

  always @(negedge clk) begin
    if (o_write_en) begin
      if (job_wr == 0) first_word = o_data_out;
      job_wr++;
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(o_write_addr), 64'(e.addr));
        check("write_data", o_data_out, e.data);
      end
    end
    if (o_done) done_cnt++;
  end

  task automatic start_job(input logic [1:0] mode, input logic [7:0] addr, input logic [7:0] size);
    @(negedge clk);
    i_p_mode = mode;
    i_o_start_addr = addr;
    i_o_size = size;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int d0;
    int i;
    bit toggle;
    n = int'(v.size) * int'(v.size);
    m_w = (v.mode == 2'b01) ? 4 : (v.mode == 2'b10) ? 2 : 8;
    m_word = '0;
    m_lanes = 0;
    m_addr = v.addr;
    job_wr = 0;
    d0 = done_cnt;
    start_job(v.mode, v.addr, v.size);
    if (n == 0) begin
      check("size0_done", 64'(o_done), 64'd1);
      check("size0_ready", 64'(o_ready), 64'd0);
    end else begin
      check("start_ready", 64'(o_ready), 64'd1);
      check("start_busy", 64'(o_busy), 64'd1);
      i = 0;
      toggle = 1'b0;
      while (i < n) begin
        if (v.gap && toggle) begin
          i_valid = 1'b0;
          toggle = 1'b0;
        end else begin
          i_valid = 1'b1;
          i_data = elem_of(v.kind, i);
          mdl_push(i_data, i == n - 1);
          i++;
          toggle = 1'b1;
        end
        @(negedge clk);
      end
      i_valid = 1'b0;
      check("done_with_last", 64'(o_done), 64'd1);
      check("write_with_last", 64'(o_write_en), 64'd1);
    end
    @(negedge clk);
    #1;
    check("busy_after", 64'(o_busy), 64'd0);
    check("ready_after", 64'(o_ready), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("write_count", 64'(job_wr), 64'(v.nw));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (v.nw > 0) check("first_word", first_word, v.w0);
  endtask

  task automatic abort_job(input bit use_rst);
    int d0;
    d0 = done_cnt;
    job_wr = 0;
    start_job(2'b00, 8'h10, 8'd3);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data = 8'(i + 1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (use_rst) i_rst = 1'b1;
    else i_reg_clear = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_reg_clear = 1'b0;
    #1;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd0);
    check("abort_done", 64'(o_done), 64'd0);
    check("abort_wr_en", 64'(o_write_en), 64'd0);
    check("abort_wr_addr", 64'(o_write_addr), 64'd0);
    check("abort_data", o_data_out, 64'd0);
    @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_no_write", 64'(job_wr), 64'd0);
    run_job(vt[0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{mode: 2'b00, addr: 8'h10, size: 8'd3, kind: 0, gap: 1'b0, nw: 2, w0: 64'h0807060504030201};
    vt[1] = '{mode: 2'b10, addr: 8'h20, size: 8'd4, kind: 1, gap: 1'b0, nw: 1, w0: 64'h00000000FFFFFFFF};
    vt[2] = '{mode: 2'b01, addr: 8'h30, size: 8'd4, kind: 2, gap: 1'b1, nw: 1, w0: 64'hFEDCBA9876543210};
    vt[3] = '{mode: 2'b00, addr: 8'hFF, size: 8'd4, kind: 2, gap: 1'b0, nw: 2, w0: 64'h0706050403020100};
    vt[4] = '{mode: 2'b11, addr: 8'h05, size: 8'd3, kind: 0, gap: 1'b0, nw: 2, w0: 64'h0807060504030201};
    vt[5] = '{mode: 2'b00, addr: 8'h40, size: 8'd0, kind: 0, gap: 1'b0, nw: 0, w0: 64'h0};
    vt[6] = '{mode: 2'b01, addr: 8'h50, size: 8'd5, kind: 2, gap: 1'b0, nw: 2, w0: 64'hFEDCBA9876543210};

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_wr_en", 64'(o_write_en), 64'd0);
    check("rst_wr_addr", 64'(o_write_addr), 64'd0);
    check("rst_data", o_data_out, 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);

    for (int t = 0; t < 7; t++) run_job(vt[t]);

    abort_job(1'b0);
    abort_job(1'b1);

    @(negedge clk);
    i_o_size = 8'd3;
    i_start = 1'b1;
    i_reg_clear = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_reg_clear = 1'b0;
    check("collide_busy", 64'(o_busy), 64'd0);
    check("collide_ready", 64'(o_ready), 64'd0);
    @(negedge clk);
    check("collide_done", 64'(o_done), 64'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
